five_stage_hazard_unit: RTL and testbench

Hazard and forwarding controller for the five-stage core. It tracks a shadow scoreboard of the instructions in the execute, memory and writeback stages and drives the decode unit's `rs1_data_bypass` / `rs2_data_bypass` selects. It also generates load-use stalls, data-memory wait freezes and branch/JAL flushes. It sits beside `five_stage_decode_unit` and is the only source of its bypass selects and of the pipeline stall/flush controls.

---
 rtl/five_stage_pkg.sv | 28 ++
 rtl/hazard_bypass_select.sv | 30 +++
 rtl/five_stage_hazard_unit.sv | 128 ++++++++++++
 tb/tb_five_stage_hazard_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/five_stage_pkg.sv
// Shared types for the five-stage core: bypass select encodings and the
// hazard unit's per-stage scoreboard entry.
package five_stage_pkg;

  localparam logic [1:0] BYP_REGFILE   = 2'b00;
  localparam logic [1:0] BYP_EXECUTE   = 2'b01;
  localparam logic [1:0] BYP_MEMORY    = 2'b10;
  localparam logic [1:0] BYP_WRITEBACK = 2'b11;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       load;
    logic       mem;
  } sb_entry_t;

  // Entry will write the given source register.
  function automatic logic sb_writes(input sb_entry_t e, input logic [4:0] rs);
    return e.valid && e.reg_write && (e.rd == rs);
  endfunction

  // Entry is a load whose result the given source register still waits for.
  function automatic logic sb_load_hit(input sb_entry_t e, input logic [4:0] rs);
    return e.valid && e.load && (e.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_bypass_select.sv
// Priority match of one decode source against the EX/MEM/WB scoreboard
// entries; also flags a pending load in EX or MEM that the source needs.
module hazard_bypass_select
  import five_stage_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       used,
  input  sb_entry_t  ex,
  input  sb_entry_t  mem,
  input  sb_entry_t  wb,
  output logic [1:0] sel,
  output logic       load_hit
);

  always_comb begin
    sel      = BYP_REGFILE;
    load_hit = 1'b0;
    if (used && (rs != 5'd0)) begin
      if (sb_writes(ex, rs)) begin
        sel = BYP_EXECUTE;
      end else if (sb_writes(mem, rs)) begin
        sel = BYP_MEMORY;
      end else if (sb_writes(wb, rs)) begin
        sel = BYP_WRITEBACK;
      end
      load_hit = sb_load_hit(ex, rs) || sb_load_hit(mem, rs);
    end
  end

endmodule

// File: rtl/five_stage_hazard_unit.sv
// Hazard and forwarding controller: shadow scoreboard, bypass selects, load-use
// stalls, memory-wait freezes and redirect flushes. HAZARD_STATS_EN adds counters.
module five_stage_hazard_unit
  import five_stage_pkg::*;
#(
  parameter int          CORE       = 0,
  parameter int unsigned STAT_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [4:0]            id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_access,
  input  logic                  ex_redirect,
  input  logic                  dmem_ready,
  output logic [1:0]            rs1_data_bypass,
  output logic [1:0]            rs2_data_bypass,
  output logic                  stall_fetch,
  output logic                  stall_decode,
  output logic                  stall_execute,
  output logic                  stall_memory,
  output logic                  flush_decode,
  output logic                  flush_execute,
  output logic [STAT_WIDTH-1:0] stall_cycles,
  output logic [STAT_WIDTH-1:0] flush_cycles
);

  sb_entry_t ex_q, mem_q, wb_q;
  sb_entry_t ex_d, mem_d, wb_d;
  logic      rs1_load_hit, rs2_load_hit;
  logic      freeze, redirect, load_use;

  hazard_bypass_select u_rs1_select (
    .rs       (id_rs1),
    .used     (id_rs1_used),
    .ex       (ex_q),
    .mem      (mem_q),
    .wb       (wb_q),
    .sel      (rs1_data_bypass),
    .load_hit (rs1_load_hit)
  );

  hazard_bypass_select u_rs2_select (
    .rs       (id_rs2),
    .used     (id_rs2_used),
    .ex       (ex_q),
    .mem      (mem_q),
    .wb       (wb_q),
    .sel      (rs2_data_bypass),
    .load_hit (rs2_load_hit)
  );

  // Redirect is gated by reset so flushes drop immediately on an async reset.
  always_comb begin
    freeze   = mem_q.valid && mem_q.mem && !dmem_ready;
    redirect = reset && ex_redirect && !freeze;
    load_use = !freeze && !redirect && (rs1_load_hit || rs2_load_hit);

    stall_fetch   = freeze || load_use;
    stall_decode  = freeze || load_use;
    stall_execute = freeze;
    stall_memory  = freeze;
    flush_decode  = redirect;
    flush_execute = redirect;
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!freeze) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (redirect || load_use) begin
        ex_d = '0;
      end else begin
        ex_d = '{valid:     id_valid,
                 rd:        id_rd,
                 reg_write: id_reg_write,
                 load:      id_mem_read,
                 mem:       id_mem_access};
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STAT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_decode && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + STAT_WIDTH'(1);
      if (flush_decode && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + STAT_WIDTH'(1);
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

  // A squashed decode instruction must never also be held.
  assert property (@(posedge clock) disable iff (!reset) !(stall_decode && flush_decode))
    else $error("hazard unit core %0d: stall and flush together", CORE);

endmodule

// File: tb/tb_five_stage_hazard_unit.sv
// Self-checking bench for five_stage_hazard_unit: directed scenarios then random
// traffic, scored against an in-flight instruction list model.
module tb_five_stage_hazard_unit;

  localparam int unsigned StatWidth = 16;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 id_valid, id_rs1_used, id_rs2_used;
  logic [4:0]           id_rs1, id_rs2, id_rd;
  logic                 id_reg_write, id_mem_read, id_mem_access;
  logic                 ex_redirect, dmem_ready;
  logic [1:0]           rs1_data_bypass, rs2_data_bypass;
  logic                 stall_fetch, stall_decode, stall_execute, stall_memory;
  logic                 flush_decode, flush_execute;
  logic [StatWidth-1:0] stall_cycles, flush_cycles;

  always #5 clock = ~clock;

  five_stage_hazard_unit #(
    .CORE       (0),
    .STAT_WIDTH (StatWidth)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .id_rd           (id_rd),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .id_mem_access   (id_mem_access),
    .ex_redirect     (ex_redirect),
    .dmem_ready      (dmem_ready),
    .rs1_data_bypass (rs1_data_bypass),
    .rs2_data_bypass (rs2_data_bypass),
    .stall_fetch     (stall_fetch),
    .stall_decode    (stall_decode),
    .stall_execute   (stall_execute),
    .stall_memory    (stall_memory),
    .flush_decode    (flush_decode),
    .flush_execute   (flush_execute),
    .stall_cycles    (stall_cycles),
    .flush_cycles    (flush_cycles)
  );

  typedef struct packed {
    logic [1:0]           byp1;
    logic [1:0]           byp2;
    logic                 sf, sd, se, sm, fd, fe;
    logic [StatWidth-1:0] sc, fc;
  } out_t;

  typedef struct {
    bit valid;
    int rd;
    bit wr;
    bit load;
    bit mem;
  } instr_t;

  // In-flight instructions by distance from decode: 0 = EX, 1 = MEM, 2 = WB.
  instr_t pipe[3];
  int     stall_cnt, flush_cnt;
  out_t   exp_q[$];
  string  name_q[$];
  int     checks   = 0;
  int     failures = 0;

  function automatic logic [1:0] ref_byp(input int rs, input bit used);
    if (!used || rs == 0) return 2'd0;
    for (int s = 0; s < 3; s++)
      if (pipe[s].valid && pipe[s].wr && pipe[s].rd == rs) return 2'(s + 1);
    return 2'd0;
  endfunction

  // Load result not yet in WB.
  function automatic bit ref_load_wait(input int rs, input bit used);
    if (!used || rs == 0) return 1'b0;
    for (int s = 0; s < 2; s++)
      if (pipe[s].valid && pipe[s].load && pipe[s].rd == rs) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_id(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                        input int rd, input bit wr, input bit ld, input bit mem);
    id_valid      = v;
    id_rs1        = 5'(r1);
    id_rs1_used   = u1;
    id_rs2        = 5'(r2);
    id_rs2_used   = u2;
    id_rd         = 5'(rd);
    id_reg_write  = wr;
    id_mem_read   = ld;
    id_mem_access = mem;
  endtask

  // Predict this cycle's outputs from the driven inputs, then advance the model.
  task automatic issue(input string name);
    out_t   e;
    bit     freeze, redir, lu;
    instr_t nw;
    e = '0;
    if (!reset) begin
      for (int s = 0; s < 3; s++) pipe[s] = '{default: 0};
      stall_cnt = 0;
      flush_cnt = 0;
    end else begin
      e.byp1 = ref_byp(int'(id_rs1), id_rs1_used);
      e.byp2 = ref_byp(int'(id_rs2), id_rs2_used);
      freeze = pipe[1].valid && pipe[1].mem && !dmem_ready;
      redir  = ex_redirect && !freeze;
      lu     = !freeze && !redir && (ref_load_wait(int'(id_rs1), id_rs1_used) ||
                                     ref_load_wait(int'(id_rs2), id_rs2_used));
      e.sf = freeze || lu;
      e.sd = freeze || lu;
      e.se = freeze;
      e.sm = freeze;
      e.fd = redir;
      e.fe = redir;
`ifdef HAZARD_STATS_EN
      e.sc = StatWidth'(stall_cnt);
      e.fc = StatWidth'(flush_cnt);
      if (e.sd && stall_cnt < (1 << StatWidth) - 1) stall_cnt++;
      if (e.fd && flush_cnt < (1 << StatWidth) - 1) flush_cnt++;
`endif
      if (!freeze) begin
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        nw = '{default: 0};
        if (!redir && !lu)
          nw = '{valid: id_valid, rd: int'(id_rd), wr: id_reg_write,
                 load: id_mem_read, mem: id_mem_access};
        pipe[0] = nw;
      end
    end
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic tick(input string name);
    issue(name);
    @(posedge clock);
    #1;
  endtask

  // Monitor: one expected record per cycle, compared away from the clock edge.
  initial begin
    out_t  e, a;
    string n;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a = {rs1_data_bypass, rs2_data_bypass, stall_fetch, stall_decode, stall_execute,
             stall_memory, flush_decode, flush_execute, stall_cycles, flush_cycles};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL %s: got byp=%b/%b st=%b%b%b%b fl=%b%b cnt=%0d/%0d, want byp=%b/%b st=%b%b%b%b fl=%b%b cnt=%0d/%0d",
                   n, a.byp1, a.byp2, a.sf, a.sd, a.se, a.sm, a.fd, a.fe, a.sc, a.fc,
                   e.byp1, e.byp2, e.sf, e.sd, e.se, e.sm, e.fd, e.fe, e.sc, e.fc);
        end
      end
    end
  end

  initial begin
    int kind;
    for (int s = 0; s < 3; s++) pipe[s] = '{default: 0};
    stall_cnt   = 0;
    flush_cnt   = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex_redirect = 1'b0;
    dmem_ready  = 1'b1;
    reset       = 1'b0;
    @(posedge clock);
    #1;
    tick("reset_held");
    tick("reset_held");

    reset = 1'b1;
    set_id(0, 5, 1, 0, 0, 0, 0, 0, 0);
    tick("reset_release");

    // ALU write of x5 walks EX -> MEM -> WB.
    set_id(1, 0, 0, 0, 0, 5, 1, 0, 0);
    tick("alu_x5_issue");
    set_id(1, 5, 1, 5, 1, 9, 1, 0, 0);
    tick("fwd_execute");
    set_id(1, 5, 1, 5, 1, 10, 1, 0, 0);
    tick("fwd_memory");
    set_id(1, 5, 1, 5, 1, 11, 1, 0, 0);
    tick("fwd_writeback");

    // Load-use: two stall cycles then WB forward.
    set_id(1, 0, 0, 0, 0, 7, 1, 1, 1);
    tick("load_x7_issue");
    set_id(1, 1, 0, 7, 1, 3, 1, 0, 0);
    tick("load_use_stall1");
    tick("load_use_stall2");
    tick("load_use_release");

    // Writers of x0 never forward or stall.
    set_id(1, 0, 0, 0, 0, 0, 1, 1, 1);
    tick("x0_load_issue");
    set_id(1, 0, 1, 0, 1, 4, 1, 0, 0);
    tick("x0_source");

    // Redirect beats load-use.
    set_id(1, 0, 0, 0, 0, 7, 1, 1, 1);
    tick("load_x7_again");
    set_id(1, 0, 0, 7, 1, 6, 1, 0, 0);
    ex_redirect = 1'b1;
    tick("redirect_over_load_use");
    tick("redirect_back_to_back");
    ex_redirect = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("drain");
    tick("drain");

    // Store in MEM with memory wait, reset pulsed mid-freeze.
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 1);
    tick("store_issue");
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("store_to_mem");
    dmem_ready  = 1'b0;
    ex_redirect = 1'b1;
    tick("mem_wait_freeze");
    reset = 1'b0;
    tick("reset_mid_freeze");
    reset       = 1'b1;
    ex_redirect = 1'b0;
    tick("after_reset_wait");
    dmem_ready = 1'b1;
    tick("after_reset_ready");

    // Random traffic over a small register window to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      kind = int'($urandom_range(0, 3));
      set_id($urandom_range(0, 9) < 8,
             int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 7)),
             kind <= 1, kind == 1, kind == 1 || kind == 2);
      ex_redirect = $urandom_range(0, 9) == 0;
      dmem_ready  = $urandom_range(0, 4) != 0;
      reset       = $urandom_range(0, 99) != 0;
      tick("random");
      reset = 1'b1;
    end

    @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected records left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
